mem_write_checker: RTL

Synthesizable self-checking monitor for the pipelined RISC-V core's data-memory write port.
- Holds a loadable table of expected (address, data) store pairs.
- Checks every store against the table in ordered or unordered mode, and counts passes and failures.
- Detects the end-of-test signature store and flags a stall timeout.
- Replaces ad-hoc per-address if/else checking in benches and can also be placed on FPGA builds.

---
 rtl/mem_write_checker_if.sv | 43 ++++
 rtl/mem_write_checker.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_write_checker_if.sv
// Configuration, store-port and result bundle of mem_write_checker.
interface mem_write_checker_if #(
    parameter int ADDR_W      = 32'd32,
    parameter int DATA_W      = 32'd32,
    parameter int NUM_ENTRIES = 32'd64
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = IDX_W + 32'd1;

    logic              start;
    logic              cfg_we;
    logic              cfg_clr;
    logic [IDX_W-1:0]  cfg_idx;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_data;
    logic              mem_write;
    logic [ADDR_W-1:0] data_adr;
    logic [DATA_W-1:0] write_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic              fail;
    logic              timeout;
    logic [CNT_W-1:0]  num_expected;
    logic [CNT_W-1:0]  pass_count;
    logic [CNT_W-1:0]  fail_count;
    logic [ADDR_W-1:0] first_fail_adr;
    logic [DATA_W-1:0] first_fail_data;

    modport master (
        output start, cfg_we, cfg_clr, cfg_idx, cfg_addr, cfg_data,
               mem_write, data_adr, write_data,
        input  busy, done, pass, fail, timeout, num_expected,
               pass_count, fail_count, first_fail_adr, first_fail_data
    );

    modport slave (
        input  start, cfg_we, cfg_clr, cfg_idx, cfg_addr, cfg_data,
               mem_write, data_adr, write_data,
        output busy, done, pass, fail, timeout, num_expected,
               pass_count, fail_count, first_fail_adr, first_fail_data
    );
endinterface

// File: rtl/mem_write_checker.sv
// Self-checking monitor for the core's data-memory store port (expected-table compare).
// Optional macro MWC_STOP_ON_FAIL_EN: the first mismatch ends the run in FAIL immediately.
module mem_write_checker #(
    parameter int                ADDR_W         = 32'd32,
    parameter int                DATA_W         = 32'd32,
    parameter int                NUM_ENTRIES    = 32'd64,
    parameter int                ORDERED        = 32'd1,
    parameter logic [ADDR_W-1:0] DONE_ADDR      = 32'd40,
    parameter logic [DATA_W-1:0] DONE_DATA      = 32'd30,
    parameter logic [ADDR_W-1:0] IGN_LO         = 32'd96,
    parameter logic [ADDR_W-1:0] IGN_HI         = 32'd99,
    parameter int                TIMEOUT_CYCLES = 32'd100000
) (
    input  logic               clk,
    input  logic               reset,
    mem_write_checker_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = IDX_W + 32'd1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 32'd1);

    localparam logic [CNT_W-1:0]       CNT_ONE = CNT_W'(1'b1);
    localparam logic [TO_W-1:0]        TO_ONE  = TO_W'(1'b1);
    localparam logic [TO_W-1:0]        TO_LAST = TO_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [NUM_ENTRIES-1:0] ENT_ONE = NUM_ENTRIES'(1'b1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_PASS = 3'd2,
        ST_FAIL = 3'd3,
        ST_TMO  = 3'd4
    } state_t;

    // Output flag pattern {busy, done, pass, fail, timeout} for a state
    function automatic logic [4:0] flags_f(input state_t s);
        logic [4:0] f;
        case (s)
            ST_RUN:  f = 5'b10000;
            ST_PASS: f = 5'b01100;
            ST_FAIL: f = 5'b01010;
            ST_TMO:  f = 5'b01011;
            default: f = 5'b00000;
        endcase
        return f;
    endfunction

    state_t                 state_r;
    logic                   busy_r, done_r, pass_r, fail_r, tmo_r;
    logic [ADDR_W-1:0]      tbl_adr_r [NUM_ENTRIES];
    logic [DATA_W-1:0]      tbl_dat_r [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid_r;
    logic [NUM_ENTRIES-1:0] matched_r;
    logic [CNT_W-1:0]       num_exp_r;
    logic [CNT_W-1:0]       pass_cnt_r;
    logic [CNT_W-1:0]       fail_cnt_r;
    logic [CNT_W-1:0]       ptr_r;
    logic [TO_W-1:0]        idle_r;
    logic [ADDR_W-1:0]      ff_adr_r;
    logic [DATA_W-1:0]      ff_dat_r;

    logic                   cfg_ok_s, store_s, sig_s, ign_s, ord_hit_s, hit_s, mis_s, tmo_s;
    logic [NUM_ENTRIES-1:0] cand_s, pick_s;

    assign cfg_ok_s  = (state_r != ST_RUN);
    assign store_s   = (state_r == ST_RUN) && bus.mem_write;
    assign sig_s     = store_s && (bus.data_adr == DONE_ADDR) && (bus.write_data == DONE_DATA);
    assign ign_s     = (bus.data_adr >= IGN_LO) && (bus.data_adr <= IGN_HI);
    assign ord_hit_s = (ptr_r < num_exp_r)
                       && (tbl_adr_r[ptr_r[IDX_W-1:0]] == bus.data_adr)
                       && (tbl_dat_r[ptr_r[IDX_W-1:0]] == bus.write_data);

    // Entries that could absorb the current store in unordered mode
    always_comb begin
        cand_s = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            cand_s[i] = valid_r[i] & ~matched_r[i]
                        & (tbl_adr_r[i] == bus.data_adr) & (tbl_dat_r[i] == bus.write_data);
        end
    end

    // Isolating the lowest set bit picks the lowest-index candidate without an encoder
    assign pick_s = cand_s & (~cand_s + ENT_ONE);
    assign hit_s  = store_s && !sig_s && !ign_s
                    && ((ORDERED != 32'sd0) ? ord_hit_s : (|cand_s));
    assign mis_s  = store_s && !sig_s && !ign_s && !hit_s;
    assign tmo_s  = (state_r == ST_RUN) && !bus.mem_write && (idle_r == TO_LAST);

    // Expected-table contents; valid_r qualifies every entry so no reset is needed here
    always_ff @(posedge clk) begin
        if (cfg_ok_s && bus.cfg_we && !bus.cfg_clr) begin
            tbl_adr_r[bus.cfg_idx] <= bus.cfg_addr;
            tbl_dat_r[bus.cfg_idx] <= bus.cfg_data;
        end
    end

    // Run FSM with table bookkeeping, counters and first-failure capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r                                  <= ST_IDLE;
            {busy_r, done_r, pass_r, fail_r, tmo_r}  <= 5'b00000;
            valid_r                                  <= '0;
            matched_r                                <= '0;
            num_exp_r                                <= '0;
            pass_cnt_r                               <= '0;
            fail_cnt_r                               <= '0;
            ptr_r                                    <= '0;
            idle_r                                   <= '0;
            ff_adr_r                                 <= '0;
            ff_dat_r                                 <= '0;
        end else begin
            if (cfg_ok_s && bus.cfg_clr) begin
                valid_r   <= '0;
                num_exp_r <= '0;
            end else if (cfg_ok_s && bus.cfg_we) begin
                valid_r[bus.cfg_idx] <= 1'b1;
                if (!valid_r[bus.cfg_idx]) begin
                    num_exp_r <= num_exp_r + CNT_ONE;
                end
            end

            case (state_r)
                ST_RUN: begin
                    idle_r <= bus.mem_write ? '0 : (idle_r + TO_ONE);
                    if (sig_s) begin
                        if ((fail_cnt_r == '0) && (pass_cnt_r == num_exp_r)) begin
                            state_r                                 <= ST_PASS;
                            {busy_r, done_r, pass_r, fail_r, tmo_r} <= flags_f(ST_PASS);
                        end else begin
                            state_r                                 <= ST_FAIL;
                            {busy_r, done_r, pass_r, fail_r, tmo_r} <= flags_f(ST_FAIL);
                        end
                    end else if (hit_s) begin
                        pass_cnt_r <= pass_cnt_r + CNT_ONE;
                        ptr_r      <= ptr_r + CNT_ONE;
                        matched_r  <= matched_r | pick_s;
                    end else if (mis_s) begin
                        if (!(&fail_cnt_r)) begin
                            fail_cnt_r <= fail_cnt_r + CNT_ONE;
                        end
                        if (fail_cnt_r == '0) begin
                            ff_adr_r <= bus.data_adr;
                            ff_dat_r <= bus.write_data;
                        end
`ifdef MWC_STOP_ON_FAIL_EN
                        state_r                                 <= ST_FAIL;
                        {busy_r, done_r, pass_r, fail_r, tmo_r} <= flags_f(ST_FAIL);
`endif
                    end else if (tmo_s) begin
                        state_r                                 <= ST_TMO;
                        {busy_r, done_r, pass_r, fail_r, tmo_r} <= flags_f(ST_TMO);
                    end
                end
                default: begin
                    if (bus.start) begin
                        state_r                                 <= ST_RUN;
                        {busy_r, done_r, pass_r, fail_r, tmo_r} <= flags_f(ST_RUN);
                        pass_cnt_r                              <= '0;
                        fail_cnt_r                              <= '0;
                        ff_adr_r                                <= '0;
                        ff_dat_r                                <= '0;
                        matched_r                               <= '0;
                        ptr_r                                   <= '0;
                        idle_r                                  <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.busy            = busy_r;
    assign bus.done            = done_r;
    assign bus.pass            = pass_r;
    assign bus.fail            = fail_r;
    assign bus.timeout         = tmo_r;
    assign bus.num_expected    = num_exp_r;
    assign bus.pass_count      = pass_cnt_r;
    assign bus.fail_count      = fail_cnt_r;
    assign bus.first_fail_adr  = ff_adr_r;
    assign bus.first_fail_data = ff_dat_r;
endmodule
